// File: rtl/parity_checker.sv
// Receive-side parity checker: recomputes parity on a valid/ready stream, tags
// each word through a one-entry registered stage and keeps error statistics.
// Optional build macro: PARITY_CHK_DROP_EN (drop erroneous words instead of tagging).
module parity_checker #(
  parameter int DATA_W = 16,
  parameter int ODD    = 0,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              parity_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              clr_i,
  output logic              sticky_err_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              alarm_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   THRESH_W = (CNT_W + 1)'(THRESH);
  localparam logic             ODD_BIT  = (ODD != 0);

  logic [DATA_W-1:0] xor_chain;
  logic              in_err;
  logic              accept;
  logic              fwd;
  logic              bad_accept;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_base;
  logic              alarm_q, alarm_d;

  // Linear XOR chain over the data word; the last tap is the reduction.
  assign xor_chain[0] = data_i[0];
  generate
    for (genvar gi = 1; gi < DATA_W; gi++) begin : g_xor
      assign xor_chain[gi] = xor_chain[gi-1] ^ data_i[gi];
    end
  endgenerate

  assign in_err     = xor_chain[DATA_W-1] ^ parity_i ^ ODD_BIT;
  assign ready_o    = !valid_q || ready_i;
  assign accept     = valid_i && ready_o;
  assign fwd        = valid_q && ready_i;
  assign bad_accept = accept && in_err;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
`ifdef PARITY_CHK_DROP_EN
      // Accept implies the stage is empty or draining, so a dropped word leaves it empty.
      valid_d = !in_err;
      if (!in_err) begin
        data_d = data_i;
      end
`else
      valid_d = 1'b1;
      data_d  = data_i;
`endif
    end else if (fwd) begin
      valid_d = 1'b0;
    end
  end

  // A clear discards the old count before this cycle's error is added.
  always_comb begin
    cnt_base = clr_i ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (bad_accept && (cnt_base != CNT_MAX)) begin
      cnt_d = cnt_base + CNT_W'(1);
    end
    sticky_d = (sticky_q && !clr_i) || bad_accept;
    alarm_d  = ({1'b0, cnt_d} >= THRESH_W);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      alarm_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      alarm_q  <= alarm_d;
    end
  end

`ifdef PARITY_CHK_DROP_EN
  assign err_o = 1'b0;
`else
  logic err_q, err_d;

  assign err_d = accept ? in_err : err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign sticky_err_o = sticky_q;
  assign err_cnt_o    = cnt_q;
  assign alarm_o      = alarm_q;

endmodule

// File: tb/tb_parity_checker.sv
// Directed bench for parity_checker: table-driven stream vectors plus hand
// sequences for back-pressure, async reset, counter saturation and word drop.
module tb_parity_checker;

`ifdef PARITY_CHK_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] data_i;
  logic        parity_i;
  logic        valid_i;
  logic        ready_i;
  logic        clr_i;

  logic        ready_o, err_o, valid_o, sticky_o, alarm_o;
  logic [15:0] data_o;
  logic [7:0]  cnt_o;

  logic        s_ready_o, s_err_o, s_valid_o, s_sticky_o, s_alarm_o;
  logic [15:0] s_data_o;
  logic [1:0]  s_cnt_o;

  int checks;
  int errors;
  int pulses;

  parity_checker u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (data_i),
    .parity_i    (parity_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .err_o       (err_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .clr_i       (clr_i),
    .sticky_err_o(sticky_o),
    .err_cnt_o   (cnt_o),
    .alarm_o     (alarm_o)
  );

  parity_checker #(.CNT_W(2), .THRESH(3)) u_sat (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (data_i),
    .parity_i    (parity_i),
    .valid_i     (valid_i),
    .ready_o     (s_ready_o),
    .data_o      (s_data_o),
    .err_o       (s_err_o),
    .valid_o     (s_valid_o),
    .ready_i     (ready_i),
    .clr_i       (clr_i),
    .sticky_err_o(s_sticky_o),
    .err_cnt_o   (s_cnt_o),
    .alarm_o     (s_alarm_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        par;
    logic        valid;
    logic        clr;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_err;
    logic        exp_sticky;
    logic [7:0]  exp_cnt;
    logic        exp_alarm;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic p, input logic v,
                       input logic r, input logic c);
    data_i   = d;
    parity_i = p;
    valid_i  = v;
    ready_i  = r;
    clr_i    = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_v;
    checks = 0;
    errors = 0;
    pulses = 0;

    //            data      par   v     clr   e_v   e_data    e_err s    cnt    alarm
    vecs[0]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[1]  = '{16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA5A5, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[2]  = '{16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 8'd1, 1'b0};
    vecs[3]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[4]  = '{16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[5]  = '{16'h00FF, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b1, 8'd1, 1'b0};
    vecs[6]  = '{16'h0F0F, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0F, 1'b0, 1'b1, 8'd1, 1'b0};
    vecs[7]  = '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 8'd2, 1'b0};
    vecs[8]  = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 8'd2, 1'b0};
    vecs[9]  = '{16'h0007, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0007, 1'b1, 1'b1, 8'd3, 1'b0};
    vecs[10] = '{16'hAAAA, 1'b1, 1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b1, 1'b1, 8'd4, 1'b1};
    vecs[11] = '{16'h0101, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b1, 8'd4, 1'b1};
    vecs[12] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b1, 8'd4, 1'b1};

    rst = 1'b1;
    drive(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven stream: reset state, good/bad words, clear, 8-word burst.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].data, vecs[i].par, vecs[i].valid, 1'b1, vecs[i].clr);
      step();
      exp_v = vecs[i].exp_valid && !(DROP && vecs[i].exp_err);
      $display("vec %0d: data_i=%h par=%b -> valid_o=%b data_o=%h err_o=%b cnt=%0d alarm=%b",
               i, vecs[i].data, vecs[i].par, valid_o, data_o, err_o, cnt_o, alarm_o);
      check($sformatf("vec%0d valid_o", i), 32'(valid_o), 32'(exp_v));
      check($sformatf("vec%0d ready_o", i), 32'(ready_o), 32'd1);
      check($sformatf("vec%0d sticky", i), 32'(sticky_o), 32'(vecs[i].exp_sticky));
      check($sformatf("vec%0d err_cnt", i), 32'(cnt_o), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d alarm", i), 32'(alarm_o), 32'(vecs[i].exp_alarm));
      if (exp_v) begin
        check($sformatf("vec%0d data_o", i), 32'(data_o), 32'(vecs[i].exp_data));
        check($sformatf("vec%0d err_o", i), 32'(err_o), 32'(vecs[i].exp_err && !DROP));
      end
    end

    // Back-pressure: word held for 3 stalled cycles, then drain and accept together.
    drive(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    drive(16'h1111, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check("bp first valid_o", 32'(valid_o), 32'd1);
    check("bp first data_o", 32'(data_o), 32'h1111);
    drive(16'h2222, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      $display("stall %0d: valid_o=%b data_o=%h ready_o=%b", k, valid_o, data_o, ready_o);
      check($sformatf("stall%0d valid_o", k), 32'(valid_o), 32'd1);
      check($sformatf("stall%0d data_o", k), 32'(data_o), 32'h1111);
      check($sformatf("stall%0d ready_o", k), 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    #1;
    check("bp release ready_o", 32'(ready_o), 32'd1);
    step();
    $display("release: valid_o=%b data_o=%h", valid_o, data_o);
    check("bp new valid_o", 32'(valid_o), 32'd1);
    check("bp new data_o", 32'(data_o), 32'h2222);
    check("bp err_cnt", 32'(cnt_o), 32'd0);
    drive(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("bp drained valid_o", 32'(valid_o), 32'd0);

    // Async reset while a word is held in the stage.
    drive(16'h3333, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("hold valid_o", 32'(valid_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: valid_o=%b data_o=%h cnt=%0d", valid_o, data_o, cnt_o);
    check("rst valid_o", 32'(valid_o), 32'd0);
    check("rst data_o", 32'(data_o), 32'h0000);
    #3;
    rst = 1'b0;
    ready_i = 1'b1;
    #1;
    check("rst ready_o", 32'(ready_o), 32'd1);

    // Saturation on the 2-bit counter instance.
    for (int k = 0; k < 5; k++) begin
      drive(16'h0001, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      $display("sat bad %0d: cnt=%0d alarm=%b", k, s_cnt_o, s_alarm_o);
      check($sformatf("sat%0d cnt", k), 32'(s_cnt_o), (k < 3) ? 32'(k + 1) : 32'd3);
      check($sformatf("sat%0d alarm", k), 32'(s_alarm_o), (k >= 2) ? 32'd1 : 32'd0);
    end
    drive(16'h0001, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    $display("clr+bad: cnt=%0d sticky=%b alarm=%b", s_cnt_o, s_sticky_o, s_alarm_o);
    check("clrbad cnt", 32'(s_cnt_o), 32'd1);
    check("clrbad sticky", 32'(s_sticky_o), 32'd1);
    check("clrbad alarm", 32'(s_alarm_o), 32'd0);
    check("clrbad main cnt", 32'(cnt_o), 32'd1);

    // good / bad / good: forwarded pulse count depends on drop mode.
    drive(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    drive(16'h0003, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    if (valid_o) pulses++;
    drive(16'h0003, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    if (valid_o) pulses++;
    drive(16'h0005, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    if (valid_o) pulses++;
    drive(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    if (valid_o) pulses++;
    $display("drop seq: pulses=%0d cnt=%0d", pulses, cnt_o);
    check("drop pulses", 32'(pulses), DROP ? 32'd2 : 32'd3);
    check("drop cnt", 32'(cnt_o), 32'd1);
    check("drop sticky", 32'(sticky_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
